// File: rtl/par2ser_pkg.sv
`default_nettype none
// ============================================================================
// Module  : par2ser_pkg
// Purpose : Constants shared by the framed parallel-to-serial transmitter and
//           its serial-to-parallel receiver: state encoding, default idle
//           symbol, default SYNC length and a counter-width helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package par2ser_pkg;

  // Transmitter state encoding
  localparam logic [0:0] c_st_sync = 1'b0;
  localparam logic [0:0] c_st_run  = 1'b1;

  // Idle / alignment symbol; the receiver's alignment detector looks for it
  localparam logic [7:0] c_idle_sym_dflt   = 8'hBC;
  localparam int         c_sync_words_dflt = 4;

  // Width of a counter that must hold the values 0..n-1 (at least 1 bit)
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/par2ser_framed_if.sv
`default_nettype none
// ============================================================================
// Module  : par2ser_framed_if
// Purpose : Word-side handshake and serial-side status bundle of the framed
//           parallel-to-serial transmitter.
// Ports   : data_in/valid_in    word source -> transmitter
//           ready_out           transmitter can take a word this cycle
//           data_out_P2S        registered serial bit
//           word_strobe         first bit of a word on data_out_P2S
//           sending_data        current bit belongs to a data word
//           sync_done           RUN state reached
//           modport master = word source, modport slave = transmitter
// Revision: 1.0 - initial release
// ============================================================================
interface par2ser_framed_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_out;
  logic             data_out_P2S;
  logic             word_strobe;
  logic             sending_data;
  logic             sync_done;

  modport master (
    output data_in, valid_in,
    input  ready_out, data_out_P2S, word_strobe, sending_data, sync_done
  );

  modport slave (
    input  data_in, valid_in,
    output ready_out, data_out_P2S, word_strobe, sending_data, sync_done
  );
endinterface
`default_nettype wire

// File: rtl/p2s_shifter.sv
`default_nettype none
// ============================================================================
// Module  : p2s_shifter
// Purpose : Bit counter plus load/shift register. On the boundary cycle
//           (bit_cnt==0) it loads a WIDTH-bit word, emitting its first bit
//           immediately; the other WIDTH-1 bits follow one per clock.
// Ports   : clk_8f, reset_L      bit clock, async active-low reset
//           load_word/load_data  word to load at the boundary, data flag
//           boundary             bit_cnt==0 (next edge loads a word)
//           ser_out              registered serial bit
//           word_strobe          ser_out carries the first bit of a word
//           sending_data         flag captured with the current word
// Revision: 1.0 - initial release
// ============================================================================
module p2s_shifter
  import par2ser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire             clk_8f,
  input  wire             reset_L,
  input  wire [WIDTH-1:0] load_word,
  input  wire             load_data,
  output logic            boundary,
  output logic            ser_out,
  output logic            word_strobe,
  output logic            sending_data
);

  localparam int                 c_cnt_w    = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

  logic [c_cnt_w-1:0] r_bit_cnt;
  logic [WIDTH-1:0]   r_shreg;
  logic               r_ser_out;
  logic               r_word_strobe;
  logic               r_sending_data;

  logic               w_first_bit;
  logic               w_next_bit;
  logic [WIDTH-1:0]   w_load_rest;
  logic [WIDTH-1:0]   w_shift_rest;

  // The register is kept WIDTH wide so the same slicing works for WIDTH=2;
  // the bit shifted in at the far end is never transmitted.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_first_bit  = load_word[WIDTH-1];
      assign w_load_rest  = {load_word[WIDTH-2:0], 1'b0};
      assign w_next_bit   = r_shreg[WIDTH-1];
      assign w_shift_rest = {r_shreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_first_bit  = load_word[0];
      assign w_load_rest  = {1'b0, load_word[WIDTH-1:1]};
      assign w_next_bit   = r_shreg[0];
      assign w_shift_rest = {1'b0, r_shreg[WIDTH-1:1]};
    end
  endgenerate

  assign boundary = (r_bit_cnt == '0);

  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      r_bit_cnt      <= '0;
      r_shreg        <= '0;
      r_ser_out      <= 1'b0;
      r_word_strobe  <= 1'b0;
      r_sending_data <= 1'b0;
    end else begin
      r_bit_cnt <= (r_bit_cnt == c_cnt_last) ? '0 : r_bit_cnt + c_cnt_w'(1);
      if (boundary) begin
        r_ser_out      <= w_first_bit;
        r_shreg        <= w_load_rest;
        r_word_strobe  <= 1'b1;
        r_sending_data <= load_data;
      end else begin
        r_ser_out      <= w_next_bit;
        r_shreg        <= w_shift_rest;
        r_word_strobe  <= 1'b0;
      end
    end
  end

  assign ser_out      = r_ser_out;
  assign word_strobe  = r_word_strobe;
  assign sending_data = r_sending_data;

endmodule
`default_nettype wire

// File: rtl/par2ser_framed.sv
`default_nettype none
// ============================================================================
// Module  : par2ser_framed
// Purpose : Framed parallel-to-serial transmitter. Sends SYNC_WORDS idle
//           symbols after reset, then serialises words accepted through a
//           valid/ready handshake with a one-word holding buffer, filling
//           gaps with IDLE_SYM.
// Ports   : clk_8f   bit clock, one serial bit per rising edge
//           reset_L  asynchronous active-low reset
//           bus      par2ser_framed_if.slave: data_in, valid_in, ready_out,
//                    data_out_P2S, word_strobe, sending_data, sync_done
// Revision: 1.0 - initial release
// ============================================================================
module par2ser_framed
  import par2ser_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] IDLE_SYM   = WIDTH'(c_idle_sym_dflt),
  parameter bit               MSB_FIRST  = 1'b1,
  parameter int               SYNC_WORDS = c_sync_words_dflt
) (
  input  wire             clk_8f,
  input  wire             reset_L,
  par2ser_framed_if.slave bus
);

  localparam int                   c_sync_cw   = cnt_width(SYNC_WORDS);
  localparam logic [c_sync_cw-1:0] c_sync_last =
    (SYNC_WORDS == 0) ? '0 : c_sync_cw'(SYNC_WORDS - 1);
  localparam logic [0:0]           c_st_reset  =
    (SYNC_WORDS == 0) ? c_st_run : c_st_sync;

  logic [0:0]           r_state;
  logic [0:0]           w_state_nxt;
  logic [c_sync_cw-1:0] r_sync_cnt;
  logic                 r_buf_full;
  logic [WIDTH-1:0]     r_buf;

  logic                 w_boundary;
  logic                 w_ready;
  logic                 w_sync_done;
  logic                 w_xfer;
  logic                 w_take;
  logic [WIDTH-1:0]     w_load_word;
  logic                 w_ser_out;
  logic                 w_word_strobe;
  logic                 w_sending_data;

  // ---------------- state machine: register ----------------
  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= c_st_reset;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- state machine: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_sync: begin
        if (w_boundary && (r_sync_cnt == c_sync_last)) begin
          w_state_nxt = c_st_run;
        end
      end
      c_st_run: begin
        w_state_nxt = c_st_run;
      end
    endcase
  end

  // ---------------- state machine: outputs ----------------
  // ready_out depends on registers only, so valid_in never reaches it
  always_comb begin
    w_ready     = (r_state == c_st_run) && !r_buf_full;
    w_sync_done = (r_state == c_st_run);
  end

  // Counts idle words sent during SYNC; the last increment is irrelevant
  // because RUN is entered on that same edge.
  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      r_sync_cnt <= '0;
    end else if (w_boundary && (r_state == c_st_sync)) begin
      r_sync_cnt <= r_sync_cnt + c_sync_cw'(1);
    end
  end

  // ---------------- handshake and holding buffer ----------------
  // A transfer needs an empty buffer and a consume needs a full one, so the
  // two never coincide. A word arriving on a boundary edge is not seen by
  // that boundary and waits for the next frame.
  assign w_xfer = bus.valid_in && w_ready;
  assign w_take = w_boundary && (r_state == c_st_run) && r_buf_full;

  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      r_buf_full <= 1'b0;
      r_buf      <= '0;
    end else if (w_xfer) begin
      r_buf_full <= 1'b1;
      r_buf      <= bus.data_in;
    end else if (w_take) begin
      r_buf_full <= 1'b0;
    end
  end

  assign w_load_word = w_take ? r_buf : IDLE_SYM;

  // ---------------- serialiser ----------------
  p2s_shifter #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shifter (
    .clk_8f       (clk_8f),
    .reset_L      (reset_L),
    .load_word    (w_load_word),
    .load_data    (w_take),
    .boundary     (w_boundary),
    .ser_out      (w_ser_out),
    .word_strobe  (w_word_strobe),
    .sending_data (w_sending_data)
  );

  assign bus.ready_out    = w_ready;
  assign bus.sync_done    = w_sync_done;
  assign bus.data_out_P2S = w_ser_out;
  assign bus.word_strobe  = w_word_strobe;
  assign bus.sending_data = w_sending_data;

endmodule
`default_nettype wire
